fpcvt_pipe: RTL
===============

FPCVT_PIPE -- requirements
Module: fpcvt_pipe

Interface
REQ-001 Parameter WIDTH, default 12, input two's-complement width; legal range 8..32.
REQ-002 Parameter SIG_W, default 4, significand width; legal range 2..WIDTH-4.
REQ-003 Parameter EXP_W, default 3, exponent width; 2^EXP_W-1 SHALL be >= WIDTH-SIG_W-1, otherwise elaboration fails.
REQ-004 Reset: one clock; reset is asynchronous and active-low.
REQ-005 Port clk, in, 1, rising-edge clock.
REQ-006 Port rst_n, in, 1, asynchronous active-low reset.
REQ-007 Port in_valid, in, 1, in_data is valid this cycle.
REQ-008 Port in_ready, out, 1, block accepts in_data this cycle.
REQ-009 Port in_data, in, WIDTH, two's-complement sample.
REQ-010 Port out_valid, out, 1, result is valid.
REQ-011 Port out_ready, in, 1, downstream accepts the result.
REQ-012 Port out_sign, out, 1, sign of the result.
REQ-013 Port out_exp, out, EXP_W, exponent E.
REQ-014 Port out_sig, out, SIG_W, significand F; the result value is F*2^E.

Function
REQ-015 A transfer occurs on a rising edge where valid and ready are both high; the input and output sides are handled independently.
REQ-016 The pipeline has three registered stages: S1 sign/abs, S2 leading-zero count/extract, S3 round/pack.
REQ-017 Latency is exactly 3 cycles from input transfer to out_valid when the output side is not stalled.
REQ-018 advance = !out_valid || out_ready.
REQ-019 in_ready = advance; when advance is low, all stages hold their contents; bubbles propagate with valid=0.
REQ-020 Sustained throughput is 1 sample/cycle while out_ready is high.
REQ-021 Sign: S1 takes sign = in_data[WIDTH-1] and mag = |in_data|.
REQ-022 Most-negative clamp: -2^(WIDTH-1) SHALL clamp to mag = 2^(WIDTH-1)-1.
REQ-023 Exponent: lz = number of leading zeros of mag over WIDTH bits; E = WIDTH-SIG_W-lz, clipped at 0.
REQ-024 Significand extraction: F = mag[E+SIG_W-1:E].
REQ-025 Zero input gives sign 0, E 0, F 0.
REQ-026 Rounding (when enabled): if E>0 and mag[E-1]=1, then F = F+1.
REQ-027 If the increment overflows F: F = 2^(SIG_W-1) and E = E+1.
REQ-028 If E then exceeds 2^EXP_W-1: E = max and F = all ones (saturate).
REQ-029 out_sign/out_exp/out_sig SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-030 On rst_n low, all stage valid bits clear immediately, without waiting for a clock edge.
REQ-031 During reset, out_valid=0, out_sign=0, out_exp=0, out_sig=0.
REQ-032 In-flight samples are discarded on reset, including reset asserted mid-stall.
REQ-033 in_ready=1 from the first edge after rst_n deasserts.

Configuration
REQ-034 With macro FPCVT_ROUND_EN defined, the S3 rounding/saturation of REQ-026..REQ-028 is built in.
REQ-035 Without FPCVT_ROUND_EN, F is truncated: the round bit is ignored and latency stays 3.

Structure
REQ-036 Package fpcvt_pkg holds the default parameter constants and the per-stage payload typedefs (sign, mag, lz, E, F).
REQ-037 Sub-module fpcvt_lzc is a parametrised combinational leading-zero counter, instantiated in S2.

Verification (WIDTH=12, SIG_W=4, EXP_W=3, FPCVT_ROUND_EN defined unless stated)
REQ-038 Exact value: 0x02C (44) -> sign 0, E 2, F 1011, 3 cycles after transfer.
REQ-039 Negative exact value: 0xFD4 (-44) -> sign 1, E 2, F 1011.
REQ-040 Rounding, with and without the macro: 0x02E (46) -> E 2, F 1100 with FPCVT_ROUND_EN; E 2, F 1011 without it.
REQ-041 Round overflow: 0x07D (125) -> E 4, F 1000.
REQ-042 Saturation: 0x7FF -> E 7, F 1111; 0x800 -> sign 1, E 7, F 1111.
REQ-043 Zero: 0x000 -> sign 0, E 0, F 0.
REQ-044 Backpressure: stream 0x02C, 0x02E, 0x07D back-to-back with out_ready held low for 5 cycles -> in_ready drops, out data stays stable, and all three results emerge in order with none lost or duplicated.
REQ-045 Reset mid-stall: assert rst_n low during a stall -> out_valid drops immediately and no stale result appears after release.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared constants and stage payload types for the fpcvt_pipe int-to-float converter.
package fpcvt_pkg;

   localparam int unsigned FPCVT_WIDTH = 12;
   localparam int unsigned FPCVT_SIG_W = 4;
   localparam int unsigned FPCVT_EXP_W = 3;

   function automatic int unsigned lz_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   localparam int unsigned FPCVT_LZ_W = lz_width(FPCVT_WIDTH);

   // Payload layouts at the default configuration; the pipe mirrors these at its own widths.
   typedef struct packed {
      logic                   sign;
      logic [FPCVT_WIDTH-1:0] mag;
   } fpcvt_s1_t;

   typedef struct packed {
      logic                   sign;
      logic [FPCVT_LZ_W-1:0]  lz;
      logic [FPCVT_EXP_W-1:0] exp;
      logic [FPCVT_SIG_W-1:0] sig;
   } fpcvt_s2_t;

   typedef struct packed {
      logic                   sign;
      logic [FPCVT_EXP_W-1:0] exp;
      logic [FPCVT_SIG_W-1:0] sig;
   } fpcvt_s3_t;

endpackage

// File: rtl/fpcvt_lzc.sv
// Parametrised combinational leading-zero counter; all-zero input yields W.
module fpcvt_lzc
   import fpcvt_pkg::*;
#(
   parameter int unsigned W  = FPCVT_WIDTH,
   parameter int unsigned CW = lz_width(W)
) (
   input  logic [W-1:0]  i_data,
   output logic [CW-1:0] o_count
);

   // Scanning upward lets the highest set bit win.
   always_comb begin
      o_count = CW'(W);
      for (int unsigned i = 0; i < W; i++) begin
         if (i_data[i]) o_count = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fpcvt_pipe.sv
// Three-stage two's-complement to F*2^E converter with valid/ready flow control.
// Optional macro FPCVT_ROUND_EN adds round-half-up with exponent bump and saturation in S3.
module fpcvt_pipe
   import fpcvt_pkg::*;
#(
   parameter int unsigned WIDTH = FPCVT_WIDTH,
   parameter int unsigned SIG_W = FPCVT_SIG_W,
   parameter int unsigned EXP_W = FPCVT_EXP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [SIG_W-1:0] out_sig
);

   localparam int unsigned LZ_W = lz_width(WIDTH);
   localparam int unsigned SPAN = WIDTH - SIG_W;

   if (WIDTH < 8 || WIDTH > 32) begin : g_bad_width
      $error("fpcvt_pipe: WIDTH out of range 8..32");
   end
   if (SIG_W < 2 || SIG_W > WIDTH - 4) begin : g_bad_sig
      $error("fpcvt_pipe: SIG_W out of range 2..WIDTH-4");
   end
   if ((2 ** EXP_W) - 1 < SPAN - 1) begin : g_bad_exp
      $error("fpcvt_pipe: EXP_W too narrow for WIDTH-SIG_W");
   end

   typedef struct packed {
      logic             sign;
      logic [WIDTH-1:0] mag;
   } s1_t;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] e;
      logic [SIG_W-1:0] f;
`ifdef FPCVT_ROUND_EN
      logic             rnd;
`endif
   } s2_t;

   logic             w_advance;
   logic             r_v1, r_v2, r_v3;
   s1_t              w_s1, r_s1;
   s2_t              w_s2, r_s2;
   logic [LZ_W-1:0]  w_lz;
   logic             w_sign;
   logic [EXP_W-1:0] w_exp;
   logic [SIG_W-1:0] w_sig;
   logic             r_sign;
   logic [EXP_W-1:0] r_exp;
   logic [SIG_W-1:0] r_sig;

   assign w_advance = !r_v3 || out_ready;
   assign in_ready  = w_advance;

   // S1: sign and magnitude; only the most-negative input negates to an MSB-set value.
   always_comb begin
      w_s1.sign = in_data[WIDTH-1];
      w_s1.mag  = in_data[WIDTH-1] ? ('0 - in_data) : in_data;
      if (w_s1.mag[WIDTH-1]) w_s1.mag = {1'b0, {(WIDTH-1){1'b1}}};
   end

   fpcvt_lzc #(.W(WIDTH), .CW(LZ_W)) u_lzc (
      .i_data  (r_s1.mag),
      .o_count (w_lz)
   );

   // S2: exponent from the zero count, then window the significand (and round bit) out of mag.
   always_comb begin
      w_s2      = '0;
      w_s2.sign = r_s1.sign;
      if (w_lz >= LZ_W'(SPAN)) w_s2.e = '0;
      else                     w_s2.e = EXP_W'(LZ_W'(SPAN) - w_lz);
`ifdef FPCVT_ROUND_EN
      {w_s2.f, w_s2.rnd} = (SIG_W+1)'({r_s1.mag, 1'b0} >> w_s2.e);
`else
      w_s2.f = SIG_W'(r_s1.mag >> w_s2.e);
`endif
   end

   // S3: round/pack.
`ifdef FPCVT_ROUND_EN
   logic [SIG_W:0] w_sum;
   logic [EXP_W:0] w_einc;

   always_comb begin
      w_sign = r_s2.sign;
      w_exp  = r_s2.e;
      w_sum  = {1'b0, r_s2.f} + (SIG_W+1)'(r_s2.rnd);
      w_einc = {1'b0, r_s2.e} + (EXP_W+1)'(1);
      w_sig  = w_sum[SIG_W-1:0];
      if (w_sum[SIG_W]) begin
         if (w_einc[EXP_W]) begin
            w_exp = '1;
            w_sig = '1;
         end else begin
            w_exp = w_einc[EXP_W-1:0];
            w_sig = {1'b1, {(SIG_W-1){1'b0}}};
         end
      end
   end
`else
   always_comb begin
      w_sign = r_s2.sign;
      w_exp  = r_s2.e;
      w_sig  = r_s2.f;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_s1   <= '0;
         r_s2   <= '0;
         r_sign <= 1'b0;
         r_exp  <= '0;
         r_sig  <= '0;
      end else if (w_advance) begin
         r_v1   <= in_valid;
         r_v2   <= r_v1;
         r_v3   <= r_v2;
         r_s1   <= w_s1;
         r_s2   <= w_s2;
         r_sign <= w_sign;
         r_exp  <= w_exp;
         r_sig  <= w_sig;
      end
   end

   assign out_valid = r_v3;
   assign out_sign  = r_sign;
   assign out_exp   = r_exp;
   assign out_sig   = r_sig;

endmodule
